// File: rtl/gbox_pkg.sv
// Shared gearbox definitions: serializer states and the rate_sel -> word width
// decode used by both the TX serializer and the RX deserializer.
package gbox_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    SHIFT     = 2'd2
  } ser_state_t;

  localparam int RATE_MIN = 3;

  // Any rate_sel outside RATE_MIN..par_dwid falls back to the full word width.
  function automatic int gbox_rate_width(input logic [3:0] rate_sel, input int par_dwid);
    int r;
    r = int'(rate_sel);
    if (r >= RATE_MIN && r <= par_dwid) return r;
    return par_dwid;
  endfunction

endpackage

// File: rtl/gbox_ser.sv
// TX gearbox serializer: loads a parallel word on word_load_en and shifts it
// out one bit per fast_clk, flagging early loads and underruns in load_err.
module gbox_ser
  import gbox_pkg::*;
#(
  parameter int PAR_DWID = 10,
  parameter int PAR_CWID = 16
) (
  input  logic                fast_clk,
  input  logic                system_reset_n,
  input  logic                tx_en,
  input  logic [3:0]          rate_sel,
  input  logic                word_load_en,
  input  logic [PAR_DWID-1:0] ser_data_in,
  input  logic                cfg_msb_first,
  input  logic                cfg_idle_val,
  input  logic                err_clr,
  output logic                ser_dout,
  output logic                ser_oe,
  output logic                load_err,
  output logic [PAR_CWID-1:0] word_cnt
);

  localparam int CNT_W = (PAR_DWID > 1) ? $clog2(PAR_DWID) : 1;

  ser_state_t          state;
  logic [PAR_DWID-1:0] shift_q;
  logic [CNT_W-1:0]    bit_cnt;

  int                  rate_w;
  logic [PAR_DWID-1:0] load_word;
  logic                cnt_zero;
  logic                do_load;
  logic                early_load;
  logic                underrun;
  logic                err_set;

  // Mask off bits at or above the width, then reorder so that the shift
  // register always emits from bit 0 regardless of the bit-order setting.
  function automatic logic [PAR_DWID-1:0] align_word(input logic [PAR_DWID-1:0] din,
                                                     input int w, input logic msb);
    logic [PAR_DWID-1:0] masked;
    logic [PAR_DWID-1:0] rev;
    masked = din & ({PAR_DWID{1'b1}} >> (PAR_DWID - w));
    for (int i = 0; i < PAR_DWID; i++) rev[i] = masked[PAR_DWID-1-i];
    return msb ? (rev >> (PAR_DWID - w)) : masked;
  endfunction

  always_comb begin
    rate_w     = gbox_rate_width(rate_sel, PAR_DWID);
    load_word  = align_word(ser_data_in, rate_w, cfg_msb_first);
    cnt_zero   = (bit_cnt == '0);
    // On the last bit a strobe only counts while tx_en is still high.
    do_load    = word_load_en &&
                 ((state == WAIT_LOAD) || ((state == SHIFT) && (!cnt_zero || tx_en)));
    early_load = (state == SHIFT) && !cnt_zero && word_load_en;
    underrun   = (state == SHIFT) && cnt_zero && tx_en && !word_load_en;
    err_set    = early_load || underrun;
  end

  always_ff @(posedge fast_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state    <= IDLE;
      shift_q  <= '0;
      bit_cnt  <= '0;
      ser_dout <= 1'b0;
      ser_oe   <= 1'b0;
      load_err <= 1'b0;
      word_cnt <= '0;
    end else begin
      if (err_set)      load_err <= 1'b1;
      else if (err_clr) load_err <= 1'b0;

      if (do_load) begin
        state    <= SHIFT;
        ser_dout <= load_word[0];
        ser_oe   <= 1'b1;
        shift_q  <= load_word >> 1;
        bit_cnt  <= CNT_W'(rate_w - 1);
        word_cnt <= word_cnt + 1'b1;
      end else begin
        case (state)
          IDLE: begin
            ser_dout <= cfg_idle_val;
            ser_oe   <= 1'b0;
            if (tx_en) state <= WAIT_LOAD;
          end
          WAIT_LOAD: begin
            ser_dout <= cfg_idle_val;
            ser_oe   <= 1'b0;
            if (!tx_en) state <= IDLE;
          end
          SHIFT: begin
            if (!cnt_zero) begin
              ser_dout <= shift_q[0];
              ser_oe   <= 1'b1;
              shift_q  <= shift_q >> 1;
              bit_cnt  <= bit_cnt - 1'b1;
            end else begin
              ser_dout <= cfg_idle_val;
              ser_oe   <= 1'b0;
              state    <= tx_en ? WAIT_LOAD : IDLE;
            end
          end
          default: begin
            state    <= IDLE;
            ser_dout <= cfg_idle_val;
            ser_oe   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gbox_ser.sv
// Bench for gbox_ser: per-cycle serial output expectations are queued when a
// word is strobed in and compared on the falling edge of the cycle they target.
module tb_gbox_ser;

  localparam int PAR_DWID = 10;
  localparam int PAR_CWID = 16;

  logic                fast_clk = 1'b0;
  logic                system_reset_n;
  logic                tx_en;
  logic [3:0]          rate_sel;
  logic                word_load_en;
  logic [PAR_DWID-1:0] ser_data_in;
  logic                cfg_msb_first;
  logic                cfg_idle_val;
  logic                err_clr;
  logic                ser_dout;
  logic                ser_oe;
  logic                load_err;
  logic [PAR_CWID-1:0] word_cnt;

  gbox_ser #(.PAR_DWID(PAR_DWID), .PAR_CWID(PAR_CWID)) dut (
    .fast_clk       (fast_clk),
    .system_reset_n (system_reset_n),
    .tx_en          (tx_en),
    .rate_sel       (rate_sel),
    .word_load_en   (word_load_en),
    .ser_data_in    (ser_data_in),
    .cfg_msb_first  (cfg_msb_first),
    .cfg_idle_val   (cfg_idle_val),
    .err_clr        (err_clr),
    .ser_dout       (ser_dout),
    .ser_oe         (ser_oe),
    .load_err       (load_err),
    .word_cnt       (word_cnt)
  );

  always #5 fast_clk = ~fast_clk;

  typedef struct {
    int    cyc;
    logic  d;
    logic  oe;
    string nm;
  } exp_t;

  typedef struct {
    logic [3:0]          rate;
    logic                msb;
    logic [PAR_DWID-1:0] data;
    string               bits;   // expected emission order, first bit leftmost
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   tb_cyc = 0;
  int   n_vec  = 0;
  int   n_bad  = 0;

  always @(posedge fast_clk) tb_cyc <= tb_cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, tb_cyc, act, req);
    end
  endtask

  always @(negedge fast_clk) begin
    while (sb.size() > 0 && sb[0].cyc <= tb_cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < tb_cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s: expectation for cycle %0d never checked", e.nm, e.cyc);
      end else begin
        chk({e.nm, " {oe,dout}"}, {30'd0, ser_oe, ser_dout}, {30'd0, e.oe, e.d});
      end
    end
  end

  task automatic tick();
    @(posedge fast_clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input int off, input logic d, input logic oe, input string nm);
    exp_t e;
    e.cyc = tb_cyc + off;
    e.d   = d;
    e.oe  = oe;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic push_bits(input string bits, input int nbits, input string nm);
    for (int k = 0; k < nbits; k++) push(k + 1, (bits[k] == "1"), 1'b1, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'd4,  1'b1, 10'h00A, "1010"};
    vecs[1] = '{4'd4,  1'b1, 10'h003, "0011"};
    vecs[2] = '{4'd1,  1'b0, 10'h3F0, "0000111111"};
    vecs[3] = '{4'd15, 1'b1, 10'h001, "0000000001"};
    vecs[4] = '{4'd3,  1'b0, 10'h3FA, "010"};
    vecs[5] = '{4'd5,  1'b1, 10'h3F3, "10011"};
    vecs[6] = '{4'd0,  1'b0, 10'h155, "1010101010"};

    system_reset_n = 1'b0;
    tx_en          = 1'b0;
    rate_sel       = 4'd10;
    word_load_en   = 1'b0;
    ser_data_in    = '0;
    cfg_msb_first  = 1'b0;
    cfg_idle_val   = 1'b1;
    err_clr        = 1'b0;

    // Reset state
    repeat (2) @(posedge fast_clk);
    @(negedge fast_clk);
    chk("reset dout", ser_dout, 0);
    chk("reset oe", ser_oe, 0);
    chk("reset load_err", load_err, 0);
    chk("reset word_cnt", word_cnt, 0);

    // LSB-first single word, then underrun
    tick();
    system_reset_n = 1'b1;
    tx_en          = 1'b1;
    tick();
    rate_sel      = 4'd10;
    ser_data_in   = 10'h2A5;
    word_load_en  = 1'b1;
    push_bits("1010010101", 10, "lsb_first");
    push(11, 1'b1, 1'b0, "underrun idle");
    tick();
    word_load_en = 1'b0;
    run(10);
    @(negedge fast_clk);
    chk("underrun load_err", load_err, 1);
    chk("single word_cnt", word_cnt, 1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge fast_clk);
    chk("err_clr after underrun", load_err, 0);

    // Seamless back-to-back stream, including out-of-range rates
    tick();
    for (int i = 0; i < 7; i++) begin
      int w;
      w             = vecs[i].bits.len();
      rate_sel      = vecs[i].rate;
      cfg_msb_first = vecs[i].msb;
      ser_data_in   = vecs[i].data;
      word_load_en  = 1'b1;
      push_bits(vecs[i].bits, w, $sformatf("stream%0d", i));
      tick();
      word_load_en = 1'b0;
      ser_data_in  = '0;
      @(negedge fast_clk);
      chk($sformatf("stream%0d word_cnt", i), word_cnt, 2 + i);
      chk($sformatf("stream%0d load_err", i), load_err, 0);
      run(w - 1);
    end
    tx_en = 1'b0;
    push(1, 1'b1, 1'b0, "stream end idle");
    tick();
    @(negedge fast_clk);
    chk("stream end load_err", load_err, 0);

    // Early load realigns; set wins over simultaneous err_clr
    tick();
    tx_en = 1'b1;
    tick();
    rate_sel      = 4'd8;
    cfg_msb_first = 1'b0;
    ser_data_in   = 10'h00F;
    word_load_en  = 1'b1;
    push_bits("1111", 4, "early first");
    tick();
    word_load_en = 1'b0;
    run(3);
    ser_data_in  = 10'h0A5;
    word_load_en = 1'b1;
    err_clr      = 1'b1;
    push_bits("10100101", 8, "early second");
    tick();
    word_load_en = 1'b0;
    err_clr      = 1'b0;
    @(negedge fast_clk);
    chk("early load_err", load_err, 1);
    chk("early word_cnt", word_cnt, 10);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge fast_clk);
    chk("early err_clr", load_err, 0);
    run(5);
    tx_en = 1'b0;
    push(1, 1'b1, 1'b0, "early end idle");
    tick();

    // tx_en dropped mid-word: word completes, last-cycle strobe ignored
    tx_en = 1'b1;
    tick();
    tick();
    rate_sel     = 4'd10;
    ser_data_in  = 10'h0F0;
    word_load_en = 1'b1;
    push_bits("0000111100", 10, "txen_drop");
    tick();
    word_load_en = 1'b0;
    run(2);
    tx_en = 1'b0;
    run(7);
    ser_data_in  = 10'h3FF;
    word_load_en = 1'b1;
    push(1, 1'b1, 1'b0, "txen_drop idle1");
    push(2, 1'b1, 1'b0, "txen_drop idle2");
    tick();
    word_load_en = 1'b0;
    @(negedge fast_clk);
    chk("txen_drop load_err", load_err, 0);
    chk("txen_drop word_cnt", word_cnt, 11);
    tick();

    // Asynchronous reset in the middle of a word
    tx_en = 1'b1;
    tick();
    tick();
    ser_data_in  = 10'h3FF;
    word_load_en = 1'b1;
    push_bits("11111", 5, "pre_reset");
    tick();
    word_load_en = 1'b0;
    run(4);
    @(negedge fast_clk);
    #2;
    system_reset_n = 1'b0;
    #1;
    chk("async reset dout", ser_dout, 0);
    chk("async reset oe", ser_oe, 0);
    chk("async reset word_cnt", word_cnt, 0);
    chk("async reset load_err", load_err, 0);
    tx_en        = 1'b0;
    cfg_idle_val = 1'b1;
    tick();
    tick();
    system_reset_n = 1'b1;
    @(negedge fast_clk);
    chk("post reset dout before edge", ser_dout, 0);
    tick();
    @(negedge fast_clk);
    chk("post reset idle dout", ser_dout, 1);
    chk("post reset oe", ser_oe, 0);

    chk("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
